// File: rtl/calc_pkg.sv
// Shared calculator definitions: key codes, keypad scanner state encoding and keymap.
// The calculator input controller decodes the same key codes.
package calc_pkg;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_MUL = 4'hC;
    localparam logic [3:0] KEY_DIV = 4'hD;
    localparam logic [3:0] KEY_EQ  = 4'hE;
    localparam logic [3:0] KEY_CLR = 4'hF;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESS    = 2'd2,
        ST_RELEASE  = 2'd3
    } key_state_e;

    // Physical layout of the calculator keypad, rows top to bottom, cols left to right.
    function automatic logic [3:0] map_key(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = KEY_ADD;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = KEY_SUB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = KEY_MUL;
            4'hC: code = KEY_CLR;
            4'hD: code = 4'h0;
            4'hE: code = KEY_EQ;
            default: code = KEY_DIV;
        endcase
        return code;
    endfunction

    function automatic logic [1:0] first_low(input logic [3:0] cols);
        logic [1:0] idx;
        if (!cols[0])      idx = 2'd0;
        else if (!cols[1]) idx = 2'd1;
        else if (!cols[2]) idx = 2'd2;
        else               idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad matrix pins plus the decoded key output towards the input controller.
// flag is a valid-only strobe: key_value is valid in the single cycle flag is high;
// there is no ready, the consumer must take it in that cycle.
interface keypad_scan_if;
    import calc_pkg::*;

    logic [3:0] key_col;
    logic [3:0] key_row;
    logic [3:0] key_value;
    logic       flag;
    logic       key_held;
    key_state_e state;

    modport master (
        input  key_col,
        output key_row, key_value, flag, key_held, state
    );

    modport slave (
        output key_col,
        input  key_row, key_value, flag, key_held, state
    );
endinterface

// File: rtl/keypad_scan_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; flops reset to all-ones or all-zeros.
module sync_2ff #(
    parameter int   WIDTH   = 4,
    parameter logic RST_VAL = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta <= {WIDTH{RST_VAL}};
            q    <= {WIDTH{RST_VAL}};
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: rotates the row drive, debounces press and release, and emits
// one key code with a single-cycle flag per physical press.
module keypad_scan
    import calc_pkg::*;
#(
    parameter int DEB_CYCLES = 20,
    parameter int ROW_DWELL  = 3
) (
    input  logic          CLK_1K,
    input  logic          RSTN,
    keypad_scan_if.master kp
);
    localparam int DW = $clog2(ROW_DWELL);
    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [DW-1:0] DWELL_LAST = DW'(ROW_DWELL - 1);
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_CYCLES - 1);

    logic          rst_meta;
    logic          rst_n;
    logic [3:0]    col_s;
    key_state_e    state;
    logic [1:0]    row_idx;
    logic [1:0]    col_idx;
    logic [DW-1:0] dwell;
    logic [CW-1:0] deb_cnt;
    logic [3:0]    key_value;
    logic          flag;
    logic          key_held;

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge CLK_1K or negedge RSTN) begin
        if (!RSTN) begin
            rst_meta <= 1'b0;
            rst_n    <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_n    <= rst_meta;
        end
    end

    sync_2ff #(.WIDTH(4), .RST_VAL(1'b1)) u_col_sync (
        .clk  (CLK_1K),
        .rstn (rst_n),
        .d    (kp.key_col),
        .q    (col_s)
    );

    always_ff @(posedge CLK_1K or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_SCAN;
            row_idx   <= 2'd0;
            col_idx   <= 2'd0;
            dwell     <= '0;
            deb_cnt   <= '0;
            key_value <= 4'h0;
            flag      <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            case (state)
                ST_SCAN: begin
                    if (dwell == DWELL_LAST) begin
                        dwell <= '0;
                        if (col_s != 4'hF) begin
                            col_idx <= first_low(col_s);
                            deb_cnt <= '0;
                            state   <= ST_DEBOUNCE;
                        end else begin
                            row_idx <= row_idx + 2'd1;
                        end
                    end else begin
                        dwell <= dwell + 1'b1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!col_s[col_idx]) begin
                        if (deb_cnt == DEB_LAST) begin
                            // Outputs load on entry so they are valid during the PRESS cycle.
                            deb_cnt   <= '0;
                            key_value <= map_key(row_idx, col_idx);
                            flag      <= 1'b1;
                            key_held  <= 1'b1;
                            state     <= ST_PRESS;
                        end else begin
                            deb_cnt <= deb_cnt + 1'b1;
                        end
                    end else begin
                        deb_cnt <= '0;
                        dwell   <= '0;
                        row_idx <= row_idx + 2'd1;
                        state   <= ST_SCAN;
                    end
                end
                ST_PRESS: begin
                    flag    <= 1'b0;
                    deb_cnt <= '0;
                    state   <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (col_s == 4'hF) begin
                        if (deb_cnt == DEB_LAST) begin
                            deb_cnt  <= '0;
                            key_held <= 1'b0;
                            dwell    <= '0;
                            row_idx  <= row_idx + 2'd1;
                            state    <= ST_SCAN;
                        end else begin
                            deb_cnt <= deb_cnt + 1'b1;
                        end
                    end else begin
                        deb_cnt <= '0;
                    end
                end
                default: state <= ST_SCAN;
            endcase
        end
    end

    assign kp.key_row   = ~(4'b0001 << row_idx);
    assign kp.key_value = key_value;
    assign kp.flag      = flag;
    assign kp.key_held  = key_held;
    assign kp.state     = state;
endmodule
